// File: rtl/line_burst_adaptor_pkg.sv
// Shared widths, state encodings and helpers for the line/burst adaptor.
package line_burst_adaptor_pkg;

    localparam int unsigned LINE_W      = 256;
    localparam int unsigned BURST_W     = 64;
    localparam int unsigned BEATS       = LINE_W / BURST_W;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned CNT_W       = $clog2(BEATS);
    localparam int unsigned STATE_W     = 3;

    typedef logic [ADDR_W-1:0]  rv32i_word;
    typedef logic [STATE_W-1:0] adaptor_state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_BURST = 3'd1;
    localparam logic [2:0] ST_RD_DONE  = 3'd2;
    localparam logic [2:0] ST_WR_BURST = 3'd3;
    localparam logic [2:0] ST_WR_DONE  = 3'd4;

    localparam rv32i_word OFFSET_MASK = rv32i_word'((64'd1 << OFFSET_BITS) - 64'd1);

    // Clear the in-line byte offset so bursts always start on a line boundary.
    function automatic rv32i_word line_align(input rv32i_word addr);
        return addr & ~OFFSET_MASK;
    endfunction

    // Pick beat idx out of a line; beat 0 is the least significant word.
    function automatic logic [BURST_W-1:0] beat_sel(input logic [LINE_W-1:0] line,
                                                    input logic [CNT_W-1:0]  idx);
        logic [BURST_W-1:0] beat;
        beat = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (idx == CNT_W'(b)) beat = line[b*BURST_W +: BURST_W];
        end
        return beat;
    endfunction

endpackage

// File: rtl/line_burst_adaptor_if.sv
// Arbiter-side line port and memory-side burst port of the adaptor.
interface line_burst_adaptor_if;
    import line_burst_adaptor_pkg::*;

    rv32i_word            address_i;
    logic                 read_i;
    logic                 write_i;
    logic [LINE_W-1:0]    line_i;
    logic [LINE_W-1:0]    line_o;
    logic                 resp_o;
    logic [BURST_W-1:0]   burst_i;
    logic                 resp_i;
    rv32i_word            address_o;
    logic                 read_o;
    logic                 write_o;
    logic [BURST_W-1:0]   burst_o;

    // The adaptor itself.
    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    // The environment: arbiter plus burst memory.
    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );

endinterface

// File: rtl/line_burst_adaptor.sv
// Splits 256-bit line requests into 4x64-bit memory bursts and reassembles reads.
module line_burst_adaptor
    import line_burst_adaptor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    line_burst_adaptor_if.slave  bus
);

    adaptor_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    rv32i_word           addr_q, addr_d;
    logic [LINE_W-1:0]   wbuf_q, wbuf_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic                resp_q, resp_d;

    logic                last_beat;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // Next-state, beat counting, line assembly and registered output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        line_d  = line_q;
        burst_d = burst_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        resp_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.read_i) begin
                    addr_d  = line_align(bus.address_i);
                    cnt_d   = '0;
                    state_d = ST_RD_BURST;
                end else if (bus.write_i) begin
                    addr_d  = line_align(bus.address_i);
                    wbuf_d  = bus.line_i;
                    cnt_d   = '0;
                    state_d = ST_WR_BURST;
                end
            end
            ST_RD_BURST: begin
                if (bus.resp_i) begin
                    for (int unsigned b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) line_d[b*BURST_W +: BURST_W] = bus.burst_i;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) state_d = ST_RD_DONE;
                end
            end
            ST_WR_BURST: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) state_d = ST_WR_DONE;
                end
            end
            ST_RD_DONE,
            ST_WR_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are registered decodes of the upcoming state.
        read_d  = (state_d == ST_RD_BURST);
        write_d = (state_d == ST_WR_BURST);
        resp_d  = (state_d == ST_RD_DONE) || (state_d == ST_WR_DONE);

        // Present the next write beat; burst_o holds once the burst ends.
        if (state_d == ST_WR_BURST) burst_d = beat_sel(wbuf_d, cnt_d);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
            burst_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            line_q  <= line_d;
            burst_q <= burst_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    assign bus.address_o = addr_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.burst_o   = burst_q;
    assign bus.line_o    = line_q;
    assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor with a queue-based response scoreboard.
module tb_line_burst_adaptor;
    import line_burst_adaptor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_burst_adaptor_if bus();

    line_burst_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] line;
        logic         is_rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] beat_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Monitor: write beats and line completions are checked against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.read_o || bus.write_o)
                chk("rd_wr_exclusive", 256'(bus.read_o & bus.write_o), 256'(0));
            if (bus.write_o) begin
                if (beat_q.size() == 0) begin
                    chk("write_o_unexpected", 256'(bus.write_o), 256'(0));
                end else begin
                    chk("burst_o", 256'(bus.burst_o), 256'(beat_q[0]));
                    if (bus.resp_i) void'(beat_q.pop_front());
                end
            end
            if (bus.resp_o) begin
                if (exp_q.size() == 0) begin
                    chk("resp_o_unexpected", 256'(bus.resp_o), 256'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("address_o_at_resp", 256'(bus.address_o), 256'(mon_e.addr));
                    if (mon_e.is_rd) chk("line_o", bus.line_o, mon_e.line);
                end
            end
        end
    end

    // Read transaction: beats are handed out on the 1-bits of pat[npat-1:0].
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [3:0][63:0] beats, input logic [7:0] pat,
                           input int npat, input logic [255:0] exp_line, input logic also_write);
        int bi = 0;
        exp_q.push_back('{addr: exp_addr, line: exp_line, is_rd: 1'b1});
        bus.address_i = addr;
        bus.read_i    = 1'b1;
        bus.write_i   = also_write;
        bus.line_i    = {4{64'h5a5a_5a5a_5a5a_5a5a}};
        @(posedge clk); #1;
        chk("read_o_rise", 256'(bus.read_o), 256'(1));
        chk("address_o_latch", 256'(bus.address_o), 256'(exp_addr));
        bus.address_i = 32'hdead_beef;
        for (int i = 0; i < npat; i++) begin
            bus.resp_i = pat[i];
            if (pat[i]) begin
                bus.burst_i = beats[bi];
                bi++;
            end else begin
                bus.burst_i = 64'hffff_ffff_ffff_ffff;
            end
            @(posedge clk); #1;
            if (i < npat - 1) chk("read_o_hold", 256'(bus.read_o), 256'(1));
        end
        bus.resp_i = 1'b0;
        chk("resp_o_after_last_beat", 256'(bus.resp_o), 256'(1));
        chk("read_o_drop", 256'(bus.read_o), 256'(0));
        @(posedge clk); #1;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        chk("resp_o_single_pulse", 256'(bus.resp_o), 256'(0));
    endtask

    // Write transaction: beats are accepted on the 1-bits of pat[npat-1:0].
    task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [3:0][63:0] beats, input logic [7:0] pat, input int npat);
        exp_q.push_back('{addr: exp_addr, line: '0, is_rd: 1'b0});
        for (int b = 0; b < 4; b++) beat_q.push_back(beats[b]);
        bus.address_i = addr;
        bus.write_i   = 1'b1;
        bus.line_i    = beats;
        @(posedge clk); #1;
        chk("write_o_rise", 256'(bus.write_o), 256'(1));
        chk("address_o_latch_wr", 256'(bus.address_o), 256'(exp_addr));
        bus.line_i    = ~bus.line_i;
        bus.address_i = 32'h0bad_0bad;
        for (int i = 0; i < npat; i++) begin
            bus.resp_i = pat[i];
            @(posedge clk); #1;
        end
        bus.resp_i = 1'b0;
        chk("resp_o_after_last_accept", 256'(bus.resp_o), 256'(1));
        chk("write_o_drop", 256'(bus.write_o), 256'(0));
        @(posedge clk); #1;
        bus.write_i = 1'b0;
        chk("resp_o_single_pulse_wr", 256'(bus.resp_o), 256'(0));
    endtask

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'hdddd_dddd_dddd_dddd, 64'hcccc_cccc_cccc_cccc,
                                       64'hbbbb_bbbb_bbbb_bbbb, 64'haaaa_aaaa_aaaa_aaaa};
    localparam logic [255:0] LINE_W1 = {64'ha5a5_a5a5_0000_0003, 64'h0f0f_0f0f_0000_0002,
                                        64'hfedc_ba98_7654_3210, 64'h0123_4567_89ab_cdef};
    localparam logic [255:0] LINE_C = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                                       64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};

    initial begin
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.line_i    = '0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;

        // Reset values
        #1;
        chk("reset_read_o",    256'(bus.read_o),    256'(0));
        chk("reset_write_o",   256'(bus.write_o),   256'(0));
        chk("reset_resp_o",    256'(bus.resp_o),    256'(0));
        chk("reset_address_o", 256'(bus.address_o), 256'(0));
        chk("reset_burst_o",   256'(bus.burst_o),   256'(0));
        chk("reset_line_o",    bus.line_o,          256'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Contiguous read
        do_read(32'h0000_1234, 32'h0000_1220, LINE_A, 8'b0000_1111, 4, LINE_A, 1'b0);

        // Gapped write; line_i/address_i scrambled after acceptance
        do_write(32'h0000_8044, 32'h0000_8040, LINE_W1, 8'b0110_0101, 7);
        chk("burst_o_hold_after_write", 256'(bus.burst_o), 256'(64'ha5a5_a5a5_0000_0003));

        // Simultaneous read and write request: read wins, gapped beats
        do_read(32'h0000_00ff, 32'h0000_00e0, LINE_B, 8'b0001_1011, 5, LINE_B, 1'b1);

        // Stray strobes in IDLE
        for (int i = 0; i < 3; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'h0bad_f00d_0bad_f00d;
            @(posedge clk); #1;
            chk("stray_read_o",  256'(bus.read_o),  256'(0));
            chk("stray_write_o", 256'(bus.write_o), 256'(0));
            chk("stray_line_o",  bus.line_o,        LINE_B);
        end
        bus.resp_i = 1'b0;
        @(posedge clk); #1;

        // Back-to-back read then write
        do_read(32'hffff_ffff, 32'hffff_ffe0, LINE_C, 8'b0000_1111, 4, LINE_C, 1'b0);
        do_write(32'h0000_0020, 32'h0000_0020, LINE_A, 8'b0000_1111, 4);

        // Reset after the second beat of a read
        bus.address_i = 32'h0000_0044;
        bus.read_i    = 1'b1;
        @(posedge clk); #1;
        chk("abort_read_o_rise", 256'(bus.read_o), 256'(1));
        bus.resp_i  = 1'b1;
        bus.burst_i = 64'h7777_7777_7777_7777;
        @(posedge clk); #1;
        bus.burst_i = 64'h8888_8888_8888_8888;
        @(posedge clk); #1;
        bus.resp_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("abort_read_o", 256'(bus.read_o),    256'(0));
        chk("abort_line_o", bus.line_o,          256'(0));
        chk("abort_resp_o", 256'(bus.resp_o),    256'(0));
        chk("abort_addr_o", 256'(bus.address_o), 256'(0));
        exp_q.delete();
        bus.read_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Read after the aborted one completes normally
        do_read(32'h0000_0100, 32'h0000_0100, LINE_A, 8'b0001_0111, 5, LINE_A, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        chk("beats_drained",      256'(beat_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
